// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
//
// Purpose:
//    Single-issue execute stage for a small 16-bit datapath. Accepts one
//    operation at a time through a valid/ready handshake, computes ADD, AND,
//    NOT or a shift, and presents a registered result together with the
//    N/Z/P condition codes through a second valid/ready handshake.
//    Shifts are done iteratively, one bit position per clock, so a shift by
//    k occupies the stage for k extra cycles. Everything else finishes on
//    the accept edge.
//
// Ports:
//    clk        rising-edge clock for all state
//    rst_n      asynchronous active-low reset
//    in_valid   upstream offers an operation
//    in_ready   stage is idle and can take an operation
//    op         00 ADD, 01 AND, 10 NOT, 11 SHF
//    shf_type   00 LSHF, 01 RSHFL, 11 RSHFA, 10 behaves as RSHFL
//    shf_amt    shift distance 0..15
//    src_a      first operand (the only operand for NOT and SHF)
//    src_b      second operand (ADD and AND only)
//    ld_cc      load the condition codes from this operation's result
//    out_valid  result is being presented
//    out_ready  downstream takes the result
//    result     registered result, held in IDLE and DONE
//    cc_n/z/p   registered condition codes, exactly one set after any load
// ---------------------------------------------------------------------------
module alu_exec_stage #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [1:0]       shf_type,
   input  logic [3:0]       shf_amt,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             ld_cc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cc_n,
   output logic             cc_z,
   output logic             cc_p
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_NOT = 2'b10;
   localparam logic [1:0] OP_SHF = 2'b11;

   localparam logic [1:0] SHF_LSHF  = 2'b00;
   localparam logic [1:0] SHF_RSHFA = 2'b11;

   state_t           r_state;
   state_t           w_nextState;

   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_shiftCnt;
   logic [1:0]       r_shfType;
   logic             r_ldCc;
   logic             r_ccN;
   logic             r_ccZ;
   logic             r_ccP;

   logic             w_accept;
   logic             w_shiftStart;
   logic             w_lastShift;
   logic [WIDTH-1:0] w_aluResult;
   logic [WIDTH-1:0] w_shiftOne;
   logic             w_ccLoad;
   logic [WIDTH-1:0] w_ccValue;

   // Handshake decode. A shift of zero is treated like any single-cycle
   // operation, so only a non-zero shift ever visits SHIFT. The last shift
   // cycle is the one where the remaining count is one.
   always_comb begin
      w_accept     = in_valid && (r_state == IDLE);
      w_shiftStart = w_accept && (op == OP_SHF) && (shf_amt != 4'd0);
      w_lastShift  = (r_state == SHIFT) && (r_shiftCnt == 4'd1);
   end

   // Single-cycle result for the operation being offered. A shift by zero
   // is just src_a passed through unchanged.
   always_comb begin
      w_aluResult = '0;
      case (op)
         OP_ADD:  w_aluResult = src_a + src_b;
         OP_AND:  w_aluResult = src_a & src_b;
         OP_NOT:  w_aluResult = ~src_a;
         OP_SHF:  w_aluResult = src_a;
         default: w_aluResult = '0;
      endcase
   end

   // One-bit step of the iterative shifter, using the captured shift type.
   // The unused encoding 10 falls into the logical-right branch.
   always_comb begin
      w_shiftOne = '0;
      case (r_shfType)
         SHF_LSHF:  w_shiftOne = {r_result[WIDTH-2:0], 1'b0};
         SHF_RSHFA: w_shiftOne = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
         default:   w_shiftOne = {1'b0, r_result[WIDTH-1:1]};
      endcase
   end

   // Condition codes load on whichever edge moves the stage into DONE:
   // the accept edge for single-cycle operations, the last shift edge
   // otherwise. The value loaded is the one result will take on that edge.
   always_comb begin
      w_ccLoad  = (w_accept && !w_shiftStart && ld_cc) || (w_lastShift && r_ldCc);
      w_ccValue = w_accept ? w_aluResult : w_shiftOne;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. out_ready only matters once the result is on
   // display; in SHIFT it is ignored.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_shiftStart) begin
               w_nextState = SHIFT;
            end else if (w_accept) begin
               w_nextState = DONE;
            end
         end
         SHIFT: begin
            if (w_lastShift) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Handshake outputs decoded purely from the state, so neither ready nor
   // valid has a combinational path from the inputs.
   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   // Datapath registers. On a non-zero shift the operand is parked in the
   // result register and shifted in place; the count tracks the shifts still
   // to do. Result is untouched in IDLE (without accept) and in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result   <= '0;
         r_shiftCnt <= 4'd0;
         r_shfType  <= 2'b00;
         r_ldCc     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_result   <= w_aluResult;
            r_shiftCnt <= shf_amt;
            r_shfType  <= shf_type;
            r_ldCc     <= ld_cc;
         end else if (r_state == SHIFT) begin
            r_result   <= w_shiftOne;
            r_shiftCnt <= r_shiftCnt - 4'd1;
         end
      end
   end

   // Condition code registers. Reset value is Z so that exactly one flag is
   // always set; when no load is requested they keep their old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ccN <= 1'b0;
         r_ccZ <= 1'b1;
         r_ccP <= 1'b0;
      end else if (w_ccLoad) begin
         r_ccN <= w_ccValue[WIDTH-1];
         r_ccZ <= (w_ccValue == '0);
         r_ccP <= !w_ccValue[WIDTH-1] && (w_ccValue != '0);
      end
   end

   assign result = r_result;
   assign cc_n   = r_ccN;
   assign cc_z   = r_ccZ;
   assign cc_p   = r_ccP;

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage
//
// Self-checking bench for alu_exec_stage. The driver offers operations and,
// at the moment an offer is certain to be accepted, pushes the expected
// result, condition codes and latency into a queue. An independent monitor
// watches the output side, randomly stalls out_ready, and pops/compares each
// presented result. Expected values come either from directed constants or
// from a whole-operation arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;

   typedef struct {
      logic [15:0] res;
      logic [2:0]  cc;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [1:0]  shf_type;
   logic [3:0]  shf_amt;
   logic [15:0] src_a;
   logic [15:0] src_b;
   logic        ld_cc;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        cc_n;
   logic        cc_z;
   logic        cc_p;

   exp_t        expQ[$];
   int          checkCount = 0;
   int          passCount  = 0;
   int          cycle      = 0;
   int          pushed     = 0;
   int          popped     = 0;
   int          discarded  = 0;
   logic [2:0]  modelCc    = 3'b010;

   bit          seen        = 0;
   bit          idleNext    = 0;
   bit          randomReady = 0;
   int          stallHold   = 0;
   int          held        = 0;
   logic [15:0] heldVal     = '0;

   alu_exec_stage #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .shf_type  (shf_type),
      .shf_amt   (shf_amt),
      .src_a     (src_a),
      .src_b     (src_b),
      .ld_cc     (ld_cc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cc_n      (cc_n),
      .cc_z      (cc_z),
      .cc_p      (cc_p)
   );

   // 10 ns clock and a free-running cycle count used for latency checks.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle <= cycle + 1;

   // Whole-operation reference: shifts are done in one step with the
   // language's shift operators rather than bit by bit.
   function automatic logic [15:0] modelResult(input logic [1:0] o, input logic [1:0] t,
                                               input logic [3:0] amt,
                                               input logic [15:0] a, input logic [15:0] b);
      logic [15:0] r;
      int          k;
      k = int'(amt);
      case (o)
         2'b00:   r = a + b;
         2'b01:   r = a & b;
         2'b10:   r = ~a;
         default: begin
            if (t == 2'b00)      r = a << k;
            else if (t == 2'b11) r = 16'($signed(a) >>> k);
            else                 r = a >> k;
         end
      endcase
      return r;
   endfunction

   function automatic logic [2:0] ccOf(input logic [15:0] r);
      return {r[15], (r == 16'h0000), (!r[15] && (r != 16'h0000))};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      checkCount++;
      if (got === want) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Offers one operation, waiting (bounded) for in_ready. The expectation is
   // pushed on the negedge before the accepting edge. With useExp the given
   // constants are the expected result/CC, otherwise the model supplies them.
   task automatic applyStimulus(input logic [1:0] o, input logic [1:0] t, input logic [3:0] amt,
                                input logic [15:0] a, input logic [15:0] b, input logic ld,
                                input bit useExp, input logic [15:0] expRes, input logic [2:0] expCc);
      int   waited;
      exp_t e;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         checkOutput("acceptTimeout", 32'(in_ready), 32'd1);
         return;
      end
      op       = o;
      shf_type = t;
      shf_amt  = amt;
      src_a    = a;
      src_b    = b;
      ld_cc    = ld;
      in_valid = 1'b1;
      e.res = useExp ? expRes : modelResult(o, t, amt, a, b);
      if (useExp) begin
         modelCc = expCc;
      end else if (ld) begin
         modelCc = ccOf(e.res);
      end
      e.cc  = modelCc;
      e.lat = (o == 2'b11) ? int'(amt) : 0;
      e.acc = cycle + 1;
      expQ.push_back(e);
      pushed++;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drainQueue", 32'(expQ.size()), 32'd0);
   endtask

   // Monitor: compares each presented result on its first cycle, checks it
   // stays stable while stalled, and that the stage is idle right after the
   // handshake. out_ready is toggled randomly when nothing is presented to
   // show it is ignored outside DONE.
   always @(negedge clk) begin
      exp_t cur;
      bit   rdy;
      if (!rst_n) begin
         seen      = 0;
         idleNext  = 0;
         out_ready = 1'b0;
      end else begin
         if (idleNext) begin
            checkOutput("idleAfterHandshake", 32'(in_ready), 32'd1);
            idleNext = 0;
         end
         if (out_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedValid", 32'd1, 32'd0);
               out_ready = 1'b1;
            end else begin
               cur = expQ[0];
               if (!seen) begin
                  checkOutput("latency", 32'(cycle - cur.acc), 32'(cur.lat));
                  checkOutput("result", 32'(result), 32'(cur.res));
                  checkOutput("condCodes", 32'({cc_n, cc_z, cc_p}), 32'(cur.cc));
                  seen    = 1;
                  held    = 0;
                  heldVal = result;
               end else begin
                  checkOutput("resultStable", 32'(result), 32'(heldVal));
               end
               checkOutput("inReadyLowInDone", 32'(in_ready), 32'd0);
               if (held < stallHold)  rdy = 1'b0;
               else if (randomReady)  rdy = ($urandom_range(0, 3) != 0);
               else                   rdy = 1'b1;
               held++;
               if (rdy) begin
                  void'(expQ.pop_front());
                  popped++;
                  seen     = 0;
                  idleNext = 1;
               end
               out_ready = rdy;
            end
         end else begin
            out_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin
      int validSeen;
      int gap;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op        = 2'b00;
      shf_type  = 2'b00;
      shf_amt   = 4'd0;
      src_a     = '0;
      src_b     = '0;
      ld_cc     = 1'b0;
      out_ready = 1'b0;

      // Reset values while held in reset, then first edge after release.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetResult", 32'(result), 32'h0);
      checkOutput("resetCc", 32'({cc_n, cc_z, cc_p}), 32'b010);
      checkOutput("resetInReady", 32'(in_ready), 32'd1);
      checkOutput("resetOutValid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("postResetInReady", 32'(in_ready), 32'd1);
      checkOutput("postResetOutValid", 32'(out_valid), 32'd0);

      // Directed cases with hand-computed expectations.
      applyStimulus(2'b00, 2'b00, 4'd0,  16'h7FFF, 16'h0001, 1'b1, 1, 16'h8000, 3'b100);
      applyStimulus(2'b00, 2'b00, 4'd0,  16'hFFFF, 16'h0001, 1'b1, 1, 16'h0000, 3'b010);
      applyStimulus(2'b01, 2'b00, 4'd0,  16'hF0F0, 16'h0FF0, 1'b0, 1, 16'h00F0, 3'b010);
      applyStimulus(2'b11, 2'b11, 4'd15, 16'h8001, 16'h0000, 1'b1, 1, 16'hFFFF, 3'b100);
      applyStimulus(2'b11, 2'b00, 4'd4,  16'h0001, 16'h0000, 1'b1, 1, 16'h0010, 3'b001);
      applyStimulus(2'b11, 2'b10, 4'd3,  16'h8000, 16'h0000, 1'b1, 1, 16'h1000, 3'b001);
      applyStimulus(2'b11, 2'b01, 4'd0,  16'h8421, 16'h0000, 1'b1, 1, 16'h8421, 3'b100);
      waitDrain();

      // Result held across a five-cycle output stall.
      stallHold = 5;
      applyStimulus(2'b10, 2'b00, 4'd0,  16'h00FF, 16'h0000, 1'b1, 1, 16'hFF00, 3'b100);
      waitDrain();
      stallHold = 0;

      // Reset in the middle of a ten-bit shift discards the operation.
      applyStimulus(2'b11, 2'b00, 4'd10, 16'h0F0F, 16'h0000, 1'b1, 0, 16'h0000, 3'b000);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midShiftResetResult", 32'(result), 32'h0);
      checkOutput("midShiftResetCc", 32'({cc_n, cc_z, cc_p}), 32'b010);
      checkOutput("midShiftResetInReady", 32'(in_ready), 32'd1);
      discarded += expQ.size();
      expQ.delete();
      seen    = 0;
      modelCc = 3'b010;
      @(negedge clk);
      rst_n = 1'b1;
      validSeen = 0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) validSeen++;
      end
      checkOutput("noValidAfterReset", 32'(validSeen), 32'd0);

      // Random back-to-back traffic with random output stalls.
      randomReady = 1;
      for (int i = 0; i < 250; i++) begin
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge clk);
         applyStimulus(2'($urandom), 2'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
                       1'($urandom), 0, 16'h0000, 3'b000);
      end
      waitDrain();
      checkOutput("noLossOrDuplication", 32'(popped + discarded), 32'(pushed));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
